stage_exe_mdu: RTL and testbench

//  Parametrised MIPS execute stage: EX/MEM pipeline register, 2-source operand forwarding, branch target adder,

---
 rtl/stage_exe_mdu.sv | 199 +++++++++++++++++++
 tb/tb_stage_exe_mdu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_exe_mdu.sv
// rtl/stage_exe_mdu.sv - MIPS execute stage: forwarding, ALU, EX/MEM register, iterative MUL/DIV unit with HI/LO
module stage_exe_mdu #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  nop_id,
    input  logic [DATA_W-1:0]     data_a,
    input  logic [DATA_W-1:0]     data_b,
    input  logic [DATA_W-1:0]     data_imm,
    input  logic [DATA_W-1:0]     npc,
    input  logic [3:0]            alu_op,
    input  logic                  use_imm,
    input  logic                  reg_dst,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [2:0]            mdu_op,
    input  logic [1:0]            for_a,
    input  logic [1:0]            for_b,
    input  logic [DATA_W-1:0]     fwd_exe,
    input  logic [DATA_W-1:0]     fwd_mem,
    input  logic [1:0]            wbi,
    input  logic                  M,
    input  logic [1:0]            memdatasize,
    output logic [DATA_W-1:0]     out,
    output logic                  zero,
    output logic [DATA_W-1:0]     jump_address,
    output logic [REG_ADDR_W-1:0] regaddr_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [DATA_W-1:0]     data_b_o,
    output logic [1:0]            wbi_o,
    output logic                  M_o,
    output logic [1:0]            memdatasize_o,
    output logic                  nop,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opnd;
    logic                sa, sb, is_div;

    logic [DATA_W-1:0] op_a, op_b, alu_b, alu_res;
    logic [SH_W-1:0]   shamt;

    always_comb begin
        op_a = data_a;
        if (for_a == 2'b01)      op_a = fwd_exe;
        else if (for_a == 2'b10) op_a = fwd_mem;
        op_b = data_b;
        if (for_b == 2'b01)      op_b = fwd_exe;
        else if (for_b == 2'b10) op_b = fwd_mem;
    end

    assign alu_b        = use_imm ? data_imm : op_b;
    assign shamt        = op_a[SH_W-1:0];
    assign jump_address = npc + data_imm;
    assign zero         = (out == '0);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:  alu_res = op_a + alu_b;
            4'd1:  alu_res = op_a - alu_b;
            4'd2:  alu_res = op_a & alu_b;
            4'd3:  alu_res = op_a | alu_b;
            4'd4:  alu_res = op_a ^ alu_b;
            4'd5:  alu_res = ~(op_a | alu_b);
            4'd6:  alu_res = DATA_W'($signed(op_a) < $signed(alu_b));
            4'd7:  alu_res = DATA_W'(op_a < alu_b);
            4'd8:  alu_res = alu_b << shamt;
            4'd9:  alu_res = alu_b >> shamt;
            4'd10: alu_res = $unsigned($signed(alu_b) >>> shamt);
            4'd11: alu_res = alu_b << (DATA_W / 2);
            default: alu_res = '0;
        endcase
    end

    logic busy, load_bubble, mdu_start, accept, signed_op, neg_a, neg_b;
    logic [DATA_W-1:0] abs_a, abs_b;

    assign busy        = (state != S_IDLE);
    assign stall_req   = busy;
    assign load_bubble = reset | flush | stall | busy;
    assign mdu_start   = (mdu_op >= 3'd1) && (mdu_op <= 3'd4);
    assign accept      = !busy && mdu_start && !nop_id && !stall && !flush;
    assign signed_op   = (mdu_op == 3'd1) || (mdu_op == 3'd3);
    assign neg_a       = signed_op & op_a[DATA_W-1];
    assign neg_b       = signed_op & op_b[DATA_W-1];
    assign abs_a       = neg_a ? -op_a : op_a;
    assign abs_b       = neg_b ? -op_b : op_b;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [DATA_W:0]     mul_sum, div_trial;
    logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
    logic [DATA_W-1:0]   div_sub, quo_fix, rem_fix, fix_hi, fix_lo;
    logic                div_ok;

    assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next  = {mul_sum, acc[DATA_W-1:1]};
    assign div_trial = acc[2*DATA_W-1:DATA_W-1];
    assign div_ok    = (div_trial >= {1'b0, opnd});
    assign div_sub   = div_trial[DATA_W-1:0] - opnd;
    assign div_next  = {div_ok ? div_sub : div_trial[DATA_W-1:0], acc[DATA_W-2:0], div_ok};

    // A zero divisor leaves the full dividend as remainder; the quotient is forced to all ones
    assign prod_fix = (sa ^ sb) ? -acc : acc;
    assign quo_fix  = (opnd == '0) ? '1 : ((sa ^ sb) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
    assign rem_fix  = sa ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    assign fix_hi   = is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
    assign fix_lo   = is_div ? quo_fix : prod_fix[DATA_W-1:0];

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept) state_d = (mdu_op >= 3'd3) ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (count == CNT_W'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_div <= 1'b0;
        end else if (accept) begin
            count  <= CNT_W'(DATA_W);
            is_div <= (mdu_op >= 3'd3);
            sa     <= neg_a;
            sb     <= neg_b;
            if (mdu_op >= 3'd3) begin
                acc  <= {{DATA_W{1'b0}}, abs_a};
                opnd <= abs_b;
            end else begin
                acc  <= {{DATA_W{1'b0}}, abs_b};
                opnd <= abs_a;
            end
        end else if (state == S_MUL || state == S_DIV) begin
            acc   <= (state == S_MUL) ? mul_next : div_next;
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_FIX && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (!load_bubble && !nop_id && mdu_op == 3'd7) begin
            if (data_imm[0]) lo <= op_a;
            else             hi <= op_a;
        end
    end

    always_ff @(posedge clock) begin
        if (load_bubble) begin
            out           <= '0;
            regaddr_o     <= '0;
            rt_o          <= '0;
            data_b_o      <= '0;
            wbi_o         <= '0;
            M_o           <= 1'b0;
            memdatasize_o <= '0;
            nop           <= 1'b1;
        end else begin
            out           <= (mdu_op == 3'd5) ? hi : (mdu_op == 3'd6) ? lo : alu_res;
            regaddr_o     <= reg_dst ? rd_addr : rt_addr;
            rt_o          <= rt_addr;
            data_b_o      <= op_b;
            wbi_o         <= wbi;
            M_o           <= M;
            memdatasize_o <= memdatasize;
            nop           <= nop_id;
        end
    end
endmodule

// File: tb/tb_stage_exe_mdu.sv
// tb/tb_stage_exe_mdu.sv - randomized self-checking bench for stage_exe_mdu against an arithmetic reference model
module tb_stage_exe_mdu;
    logic        clock = 1'b0;
    logic        reset, stall, flush, nop_id, use_imm, reg_dst, M;
    logic [31:0] data_a, data_b, data_imm, npc, fwd_exe, fwd_mem;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr, rt_addr;
    logic [2:0]  mdu_op;
    logic [1:0]  for_a, for_b, wbi, memdatasize;

    logic [31:0] out, jump_address, data_b_o, hi, lo;
    logic [4:0]  regaddr_o, rt_o;
    logic [1:0]  wbi_o, memdatasize_o;
    logic        zero, M_o, nop, stall_req;

    logic [15:0] s_out, s_jump, s_data_b_o, s_hi, s_lo;
    logic [4:0]  s_regaddr_o, s_rt_o;
    logic [1:0]  s_wbi_o, s_memdatasize_o;
    logic        s_zero, s_M_o, s_nop, s_stall_req;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    stage_exe_mdu #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .nop_id(nop_id),
        .data_a(data_a), .data_b(data_b), .data_imm(data_imm), .npc(npc), .alu_op(alu_op),
        .use_imm(use_imm), .reg_dst(reg_dst), .rd_addr(rd_addr), .rt_addr(rt_addr), .mdu_op(mdu_op),
        .for_a(for_a), .for_b(for_b), .fwd_exe(fwd_exe), .fwd_mem(fwd_mem), .wbi(wbi), .M(M),
        .memdatasize(memdatasize), .out(out), .zero(zero), .jump_address(jump_address),
        .regaddr_o(regaddr_o), .rt_o(rt_o), .data_b_o(data_b_o), .wbi_o(wbi_o), .M_o(M_o),
        .memdatasize_o(memdatasize_o), .nop(nop), .stall_req(stall_req), .hi(hi), .lo(lo));

    stage_exe_mdu #(.DATA_W(16), .REG_ADDR_W(5)) dut16 (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .nop_id(nop_id),
        .data_a(data_a[15:0]), .data_b(data_b[15:0]), .data_imm(data_imm[15:0]), .npc(npc[15:0]),
        .alu_op(alu_op), .use_imm(use_imm), .reg_dst(reg_dst), .rd_addr(rd_addr), .rt_addr(rt_addr),
        .mdu_op(mdu_op), .for_a(for_a), .for_b(for_b), .fwd_exe(fwd_exe[15:0]), .fwd_mem(fwd_mem[15:0]),
        .wbi(wbi), .M(M), .memdatasize(memdatasize), .out(s_out), .zero(s_zero), .jump_address(s_jump),
        .regaddr_o(s_regaddr_o), .rt_o(s_rt_o), .data_b_o(s_data_b_o), .wbi_o(s_wbi_o), .M_o(s_M_o),
        .memdatasize_o(s_memdatasize_o), .nop(s_nop), .stall_req(s_stall_req), .hi(s_hi), .lo(s_lo));

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] bs;
        int sh;
        bs = b;
        sh = int'(a[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b * (32'd1 << sh);
            4'd9:  return b / (32'd1 << sh);
            4'd10: return bs >>> sh;
            4'd11: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    // Returns {HI, LO} computed with 64-bit integer arithmetic
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint av, bv, q, r;
        logic [63:0] p;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        p  = 64'd0;
        case (op)
            3'd1: p = av * bv;
            3'd2: p = {32'h0, a} * {32'h0, b};
            3'd3: if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                  else begin q = av / bv; r = av % bv; p = {r[31:0], q[31:0]}; end
            3'd4: if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                  else p = {a % b, a / b};
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; nop_id = 1'b1;
        data_a = '0; data_b = '0; data_imm = '0; npc = '0; fwd_exe = '0; fwd_mem = '0;
        alu_op = '0; use_imm = 1'b0; reg_dst = 1'b0; rd_addr = '0; rt_addr = '0;
        mdu_op = '0; for_a = '0; for_b = '0; wbi = '0; M = 1'b0; memdatasize = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; nop_id = 1'b0; alu_op = 4'd0; data_a = 32'd3; data_b = 32'd4;
        step(); step();
        tests++; if (nop !== 1'b1) begin fails++; $display("FAIL reset_nop got %0b want 1", nop); end
        tests++; if (out !== 32'd0 || zero !== 1'b1) begin fails++; $display("FAIL reset_out got %h/%b want 0/1", out, zero); end
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo got %h %h want 0 0", hi, lo); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall_req got %b want 0", stall_req); end
        idle_inputs();
    endtask

    task automatic test_add_fwd();
        nop_id = 1'b0; alu_op = 4'd0; for_a = 2'b01; fwd_exe = 32'd100; data_a = 32'd5; data_b = 32'd7;
        reg_dst = 1'b1; rd_addr = 5'd3; rt_addr = 5'd9;
        step();
        tests++; if (out !== 32'd107 || zero !== 1'b0) begin fails++; $display("FAIL add_fwd_out got %0d/%b want 107/0", out, zero); end
        tests++; if (nop !== 1'b0 || regaddr_o !== 5'd3) begin fails++; $display("FAIL add_fwd_ctl got nop=%b rd=%0d want 0/3", nop, regaddr_o); end
        stall = 1'b1;
        step();
        tests++; if (nop !== 1'b1 || out !== 32'd0) begin fails++; $display("FAIL stall_bubble got nop=%b out=%h want 1/0", nop, out); end
        idle_inputs();
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b, exp_out;
        logic [15:0] exp_ctl, got_ctl;
        for (int i = 0; i < 24; i++) begin
            data_a = $urandom; data_b = $urandom; data_imm = $urandom; npc = $urandom;
            fwd_exe = $urandom; fwd_mem = $urandom;
            alu_op = 4'($urandom_range(0, 11)); use_imm = 1'($urandom); reg_dst = 1'($urandom);
            for_a = 2'($urandom); for_b = 2'($urandom); rd_addr = 5'($urandom); rt_addr = 5'($urandom);
            wbi = 2'($urandom); M = 1'($urandom); memdatasize = 2'($urandom); nop_id = 1'($urandom);
            a = (for_a == 2'b01) ? fwd_exe : (for_a == 2'b10) ? fwd_mem : data_a;
            b = (for_b == 2'b01) ? fwd_exe : (for_b == 2'b10) ? fwd_mem : data_b;
            exp_out = ref_alu(alu_op, a, use_imm ? data_imm : b);
            exp_ctl = {reg_dst ? rd_addr : rt_addr, rt_addr, wbi, M, memdatasize, nop_id};
            step();
            got_ctl = {regaddr_o, rt_o, wbi_o, M_o, memdatasize_o, nop};
            tests++; if (out !== exp_out || zero !== (exp_out == 0)) begin fails++; $display("FAIL alu_rand op=%0d got %h want %h", alu_op, out, exp_out); end
            tests++; if (got_ctl !== exp_ctl || data_b_o !== b) begin fails++; $display("FAIL alu_ctl got %h/%h want %h/%h", got_ctl, data_b_o, exp_ctl, b); end
            tests++; if (jump_address !== npc + data_imm) begin fails++; $display("FAIL jump got %h want %h", jump_address, npc + data_imm); end
        end
        idle_inputs();
    endtask

    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int cnt;
        exp = ref_mdu(op, a, b);
        nop_id = 1'b0; mdu_op = op; data_a = a; data_b = b;
        step();
        mdu_op = 3'd0; alu_op = 4'd0;
        cnt = 0;
        while (stall_req && cnt < 200) begin
            cnt++;
            step();
        end
        tests++; if (cnt != 33) begin fails++; $display("FAIL mdu_latency op=%0d got %0d want 33", op, cnt); end
        tests++; if (nop !== 1'b1) begin fails++; $display("FAIL mdu_bubble got nop=%b want 1", nop); end
        tests++; if (hi !== exp[63:32] || lo !== exp[31:0]) begin
            fails++; $display("FAIL mdu op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, hi, lo, exp[63:32], exp[31:0]);
        end
        mdu_op = 3'd6;
        step();
        tests++; if (out !== exp[31:0]) begin fails++; $display("FAIL mflo got %h want %h", out, exp[31:0]); end
        mdu_op = 3'd5;
        step();
        tests++; if (out !== exp[63:32]) begin fails++; $display("FAIL mfhi got %h want %h", out, exp[63:32]); end
        idle_inputs();
    endtask

    task automatic test_mdu();
        logic [2:0]  op;
        logic [31:0] a, b;
        run_mdu(3'd1, -32'sd3, 32'd7);
        run_mdu(3'd4, 32'd100, 32'd7);
        run_mdu(3'd3, -32'sd7, 32'd2);
        run_mdu(3'd3, 32'd9, 32'd0);
        run_mdu(3'd3, -32'sd9, 32'd0);
        run_mdu(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mdu(3'd1, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_mdu(op, a, b);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        nop_id = 1'b0; mdu_op = 3'd7; data_a = v1; data_imm = 32'd0;
        step();
        for_a = 2'b10; fwd_mem = v2; data_imm = 32'd1;
        step();
        tests++; if (hi !== v1 || lo !== v2) begin fails++; $display("FAIL mthi_mtlo got %h %h want %h %h", hi, lo, v1, v2); end
        idle_inputs();
    endtask

    task automatic test_flush_mul();
        nop_id = 1'b0; mdu_op = 3'd7; data_a = 32'd0; data_imm = 32'd0;
        step();
        data_imm = 32'd1;
        step();
        mdu_op = 3'd1; data_a = -32'sd3; data_b = 32'd7;
        step();
        mdu_op = 3'd0;
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL flush_stall_req got %b want 0", stall_req); end
        for (int i = 0; i < 40; i++) step();
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL flush_hilo got %h %h want 0 0", hi, lo); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_div();
        nop_id = 1'b0; mdu_op = 3'd4; data_a = 32'd100; data_b = 32'd7;
        step();
        mdu_op = 3'd0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1; npc = 32'hFFFF_FFFC; data_imm = 32'd8;
        step();
        tests++; if (stall_req !== 1'b0 || nop !== 1'b1) begin fails++; $display("FAIL reset_div got stall_req=%b nop=%b want 0/1", stall_req, nop); end
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_div_hilo got %h %h want 0 0", hi, lo); end
        tests++; if (jump_address !== 32'd4) begin fails++; $display("FAIL jump_wrap got %h want 4", jump_address); end
        idle_inputs();
        step();
    endtask

    task automatic test_width16();
        int c32, c16, cyc;
        nop_id = 1'b0; mdu_op = 3'd2; data_a = 32'hFFFF_FFFF; data_b = 32'hFFFF_FFFF;
        step();
        mdu_op = 3'd0; nop_id = 1'b1;
        c32 = 0; c16 = 0; cyc = 0;
        while ((stall_req || s_stall_req) && cyc < 200) begin
            if (stall_req)   c32++;
            if (s_stall_req) c16++;
            cyc++;
            step();
        end
        tests++; if (c32 != 33 || c16 != 17) begin fails++; $display("FAIL width_latency got %0d/%0d want 33/17", c32, c16); end
        tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin fails++; $display("FAIL multu32 got %h %h want fffffffe 1", hi, lo); end
        tests++; if (s_hi !== 16'hFFFE || s_lo !== 16'd1) begin fails++; $display("FAIL multu16 got %h %h want fffe 1", s_hi, s_lo); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_add_fwd();
        test_alu_random();
        test_mdu();
        test_mthi_mtlo();
        test_flush_mul();
        test_reset_mid_div();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
